// File: rtl/ncl_ring_ctrl_if.sv
// Control/status bundle between the ring sequencer and the board-side logic.
// master = ncl_ring_ctrl, slave = button/LED logic and the ring's C pin.
interface ncl_ring_ctrl_if #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned STALL_W = 8
);
  logic               enable;
  logic               ring_tick;
  logic               ring_init;
  logic [CNT_W-1:0]   result;
  logic               result_valid;
  logic               stalled;
  logic [STALL_W-1:0] stall_count;
  logic               busy;

  modport master (
    input  enable, ring_tick,
    output ring_init, result, result_valid, stalled, stall_count, busy
  );

  modport slave (
    output enable, ring_tick,
    input  ring_init, result, result_valid, stalled, stall_count, busy
  );
endinterface

// File: rtl/ncl_ring_ctrl.sv
// Init sequencer and gated frequency meter for the NCL TH22 ring oscillator.
// Counts synchronised ring_tick edges per GATE_CYCLES window and re-inits a stalled ring.
module ncl_ring_ctrl #(
  parameter int unsigned INIT_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned GATE_CYCLES   = 1048576,
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned STALL_W       = 8
) (
  input  logic           clk_25mhz,
  input  logic           rst_n,
  ncl_ring_ctrl_if.master bus
);

  localparam int unsigned MAX_IS  = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (GATE_CYCLES > MAX_IS) ? GATE_CYCLES : MAX_IS;
  localparam int unsigned CYC_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CYC_W-1:0] INIT_LAST   = CYC_W'(INIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETTLE,
    MEASURE,
    REPORT
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   edge_cnt_nxt;
  logic               stall_now;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               tick_edge;

  // ring_tick is asynchronous; only the rising edge of the synchronised copy is used
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.ring_tick;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_edge = s2 & ~s3;

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    if (tick_edge && (edge_cnt != '1)) begin
      edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  assign stall_now = (32'(edge_cnt_nxt) < MIN_EDGES);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.enable) next_state = INIT;
      end
      INIT: begin
        if (!bus.enable)                next_state = IDLE;
        else if (cyc_cnt == INIT_LAST)  next_state = SETTLE;
      end
      SETTLE: begin
        if (!bus.enable)                 next_state = IDLE;
        else if (cyc_cnt == SETTLE_LAST) next_state = MEASURE;
      end
      MEASURE: begin
        if (!bus.enable)               next_state = IDLE;
        else if (cyc_cnt == GATE_LAST) next_state = REPORT;
      end
      REPORT: begin
        if (bus.stalled)     next_state = INIT;
        else if (bus.enable) next_state = MEASURE;
        else                 next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Report outputs are registered on entry to REPORT (including the final
  // MEASURE cycle's edge) so result, stalled and result_valid line up in REPORT.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cyc_cnt          <= '0;
      edge_cnt         <= '0;
      bus.ring_init    <= 1'b1;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.stalled      <= 1'b0;
      bus.stall_count  <= '0;
    end else begin
      state <= next_state;

      if ((next_state != state) || (state == IDLE)) cyc_cnt <= '0;
      else                                          cyc_cnt <= cyc_cnt + CYC_W'(1);

      if (state == MEASURE) edge_cnt <= edge_cnt_nxt;
      else                  edge_cnt <= '0;

      bus.ring_init    <= (next_state == IDLE) || (next_state == INIT);
      bus.result_valid <= (next_state == REPORT);

      if ((state == MEASURE) && (next_state == REPORT)) begin
        bus.result  <= edge_cnt_nxt;
        bus.stalled <= stall_now;
        if (stall_now && (bus.stall_count != '1)) begin
          bus.stall_count <= bus.stall_count + STALL_W'(1);
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_ncl_ring_ctrl.sv
// Directed bench for ncl_ring_ctrl with short windows; a second instance with
// CNT_W=5 shares all stimulus to exercise count saturation.
module tb_ncl_ring_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic tick_on = 1'b0;
  logic gen = 1'b0;
  logic man = 1'b0;
  int   tick_period = 10;
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;

  always #5 clk = ~clk;

  ncl_ring_ctrl_if #(.CNT_W(8), .STALL_W(2)) bus_a ();
  ncl_ring_ctrl_if #(.CNT_W(5), .STALL_W(2)) bus_b ();

  assign bus_a.enable    = enable;
  assign bus_b.enable    = enable;
  assign bus_a.ring_tick = tick_on ? gen : man;
  assign bus_b.ring_tick = tick_on ? gen : man;

  ncl_ring_ctrl #(
    .INIT_CYCLES(4), .SETTLE_CYCLES(8), .GATE_CYCLES(100),
    .MIN_EDGES(2), .CNT_W(8), .STALL_W(2)
  ) dut_a (
    .clk_25mhz(clk),
    .rst_n(rst_n),
    .bus(bus_a.master)
  );

  ncl_ring_ctrl #(
    .INIT_CYCLES(4), .SETTLE_CYCLES(8), .GATE_CYCLES(100),
    .MIN_EDGES(2), .CNT_W(5), .STALL_W(2)
  ) dut_b (
    .clk_25mhz(clk),
    .rst_n(rst_n),
    .bus(bus_b.master)
  );

  // Free-running tick source: toggles every tick_period/2 clk cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (tick_on) begin
        ph++;
        if (ph >= tick_period / 2) begin
          ph = 0;
          gen = ~gen;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic goto_cycle(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_a.result_valid !== 1'b1 && n < bound);
    checks++;
    if (bus_a.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: result_valid=%b after %0d cycles, required 1", bus_a.result_valid, n);
    end
  endtask

  task automatic wait_ring_low(input int bound);
    int n;
    n = 0;
    while (bus_a.ring_init !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_a.ring_init !== 1'b0) begin
      errors++;
      $display("FAIL wait_ring_low: ring_init=%b after %0d cycles, required 0", bus_a.ring_init, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; tick_on = 1'b0; man = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.ring_init, bus_a.busy, bus_a.result_valid, bus_a.stalled} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: init/busy/valid/stalled=%b required 1000",
               {bus_a.ring_init, bus_a.busy, bus_a.result_valid, bus_a.stalled});
    end
    checks++;
    if (bus_a.result !== 8'd0 || bus_a.stall_count !== 2'd0 || bus_b.result !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: result=%0d stall_count=%0d result_b=%0d required 0 0 0",
               bus_a.result, bus_a.stall_count, bus_b.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.ring_init !== 1'b1) begin
      errors++;
      $display("FAIL idle_park: busy=%b ring_init=%b required 0 1", bus_a.busy, bus_a.ring_init);
    end
  endtask

  task automatic test_stall();
    int n_hi;
    int n_lo;
    int n;
    int exp_sc;
    enable = 1'b1;
    n_hi = 0;
    @(negedge clk);
    while (bus_a.ring_init === 1'b1 && n_hi < 50) begin
      if (bus_a.busy === 1'b1) n_hi++;
      @(negedge clk);
    end
    checks++;
    if (n_hi != 4) begin
      errors++;
      $display("FAIL init_len: ring_init high for %0d cycles, required 4", n_hi);
    end
    n_lo = 0;
    while (bus_a.result_valid !== 1'b1 && bus_a.ring_init === 1'b0 && n_lo < 300) begin
      n_lo++;
      @(negedge clk);
    end
    checks++;
    if (n_lo != 108) begin
      errors++;
      $display("FAIL settle_measure_len: ring_init low %0d cycles before report, required 108", n_lo);
    end
    checks++;
    if (bus_a.result_valid !== 1'b1 || bus_a.result !== 8'd0 || bus_a.stalled !== 1'b1 ||
        bus_a.stall_count !== 2'd1) begin
      errors++;
      $display("FAIL first_stall: valid=%b result=%0d stalled=%b stall_count=%0d required 1 0 1 1",
               bus_a.result_valid, bus_a.result, bus_a.stalled, bus_a.stall_count);
    end
    @(negedge clk);
    checks++;
    if (bus_a.ring_init !== 1'b1 || bus_a.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_reinit: ring_init=%b valid=%b required 1 0", bus_a.ring_init, bus_a.result_valid);
    end
    for (int k = 2; k <= 4; k++) begin
      exp_sc = (k > 3) ? 3 : k;
      wait_valid(200, n);
      checks++;
      if (int'(bus_a.stall_count) != exp_sc || bus_a.stalled !== 1'b1) begin
        errors++;
        $display("FAIL stall_sat: window %0d stall_count=%0d stalled=%b required %0d 1",
                 k, bus_a.stall_count, bus_a.stalled, exp_sc);
      end
    end
  endtask

  task automatic test_rate_10();
    int n;
    int hi;
    enable = 1'b0;
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tick_period = 10;
    tick_on = 1'b1;
    enable = 1'b1;
    wait_valid(300, n);
    checks++;
    if (bus_a.result < 8'd9 || bus_a.result > 8'd11 || bus_a.stalled !== 1'b0 || bus_a.stall_count !== 2'd3) begin
      errors++;
      $display("FAIL rate10_first: result=%0d stalled=%b stall_count=%0d required 9..11 0 3",
               bus_a.result, bus_a.stalled, bus_a.stall_count);
    end
    hi = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus_a.ring_init !== 1'b0 || bus_a.busy !== 1'b1) hi = 1;
      if (n == 1) begin
        checks++;
        if (bus_a.result_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_pulse: result_valid=%b one cycle after report, required 0", bus_a.result_valid);
        end
      end
    end while (bus_a.result_valid !== 1'b1 && n < 300);
    checks++;
    if (n != 101 || hi != 0) begin
      errors++;
      $display("FAIL back_to_back: report spacing=%0d reinit_seen=%0d required 101 0", n, hi);
    end
    checks++;
    if (bus_a.result < 8'd9 || bus_a.result > 8'd11) begin
      errors++;
      $display("FAIL rate10_second: result=%0d required 9..11", bus_a.result);
    end
  endtask

  task automatic test_saturate();
    int n;
    tick_period = 2;
    wait_valid(300, n);
    wait_valid(300, n);
    checks++;
    if (bus_a.result !== 8'd50 || bus_a.stalled !== 1'b0) begin
      errors++;
      $display("FAIL max_rate: result=%0d stalled=%b required 50 0", bus_a.result, bus_a.stalled);
    end
    checks++;
    if (bus_b.result !== 5'd31 || bus_b.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL saturate_cnt5: result=%0d valid=%b required 31 1", bus_b.result, bus_b.result_valid);
    end
  endtask

  task automatic test_enable_drop();
    int vcount;
    int lo;
    repeat (50) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.ring_init !== 1'b0) begin
      errors++;
      $display("FAIL mid_measure: busy=%b ring_init=%b required 1 0", bus_a.busy, bus_a.ring_init);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.ring_init !== 1'b1 || bus_a.result_valid !== 1'b0 ||
        bus_a.result !== 8'd50 || bus_b.result !== 5'd31) begin
      errors++;
      $display("FAIL enable_drop: busy=%b ring_init=%b valid=%b result=%0d result_b=%0d required 0 1 0 50 31",
               bus_a.busy, bus_a.ring_init, bus_a.result_valid, bus_a.result, bus_b.result);
    end
    vcount = 0;
    lo = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus_a.result_valid === 1'b1) vcount++;
      if (bus_a.ring_init !== 1'b1) lo++;
    end
    checks++;
    if (vcount != 0 || lo != 0 || bus_a.result !== 8'd50) begin
      errors++;
      $display("FAIL idle_hold: valid_pulses=%0d ring_low=%0d result=%0d required 0 0 50",
               vcount, lo, bus_a.result);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    @(negedge clk);
    wait_ring_low(50);
    repeat (60) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.stall_count !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset: busy=%b stall_count=%0d required 1 3", bus_a.busy, bus_a.stall_count);
    end
    tick_on = 1'b0;
    man = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.ring_init !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.result !== 8'd0 ||
        bus_a.result_valid !== 1'b0 || bus_a.stalled !== 1'b0 || bus_a.stall_count !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: init=%b busy=%b result=%0d valid=%b stalled=%b sc=%0d required 1 0 0 0 0 0",
               bus_a.ring_init, bus_a.busy, bus_a.result, bus_a.result_valid, bus_a.stalled, bus_a.stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.ring_init !== 1'b1) begin
      errors++;
      $display("FAIL restart_init: busy=%b ring_init=%b required 1 1", bus_a.busy, bus_a.ring_init);
    end
  endtask

  task automatic pulse_edge(input int c);
    goto_cycle(c - 2);
    man = 1'b1;
    goto_cycle(c);
    man = 1'b0;
  endtask

  task automatic test_edge_boundary();
    wait_ring_low(50);
    cur = 0;
    pulse_edge(50);
    pulse_edge(60);
    pulse_edge(107);
    checks++;
    if (bus_a.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_cycle_valid: result_valid=%b in last measure cycle, required 0", bus_a.result_valid);
    end
    goto_cycle(108);
    checks++;
    if (bus_a.result_valid !== 1'b1 || bus_a.result !== 8'd3 || bus_a.stalled !== 1'b0) begin
      errors++;
      $display("FAIL last_edge_counted: valid=%b result=%0d stalled=%b required 1 3 0",
               bus_a.result_valid, bus_a.result, bus_a.stalled);
    end
    pulse_edge(150);
    pulse_edge(160);
    pulse_edge(170);
    goto_cycle(207);
    man = 1'b1;
    goto_cycle(209);
    checks++;
    if (bus_a.result_valid !== 1'b1 || bus_a.result !== 8'd3) begin
      errors++;
      $display("FAIL window2: valid=%b result=%0d required 1 3", bus_a.result_valid, bus_a.result);
    end
    man = 1'b0;
    pulse_edge(250);
    pulse_edge(260);
    goto_cycle(310);
    checks++;
    if (bus_a.result_valid !== 1'b1 || bus_a.result !== 8'd2 || bus_a.stalled !== 1'b0) begin
      errors++;
      $display("FAIL report_edge_dropped: valid=%b result=%0d stalled=%b required 1 2 0",
               bus_a.result_valid, bus_a.result, bus_a.stalled);
    end
    goto_cycle(411);
    checks++;
    if (bus_a.result_valid !== 1'b1 || bus_a.result !== 8'd0 || bus_a.stalled !== 1'b1 ||
        bus_a.stall_count !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_stall: valid=%b result=%0d stalled=%b sc=%0d required 1 0 1 1",
               bus_a.result_valid, bus_a.result, bus_a.stalled, bus_a.stall_count);
    end
    goto_cycle(412);
    checks++;
    if (bus_a.ring_init !== 1'b1) begin
      errors++;
      $display("FAIL stall_to_init: ring_init=%b required 1", bus_a.ring_init);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_rate_10();
    test_saturate();
    test_enable_drop();
    test_reset_mid();
    test_edge_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
